// File: rtl/uart_tx_packet_pkg.sv
// Shared UART line levels, frame geometry and state encodings for the TX packet path.
// The same constants describe the frames that uart_rx expects.
package uart_tx_packet_pkg;

  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam int   UART_DATA_BITS = 8;
  localparam int   UART_PKT_BYTES = 5;

  typedef enum logic [1:0] {
    FRM_IDLE,
    FRM_START,
    FRM_DATA,
    FRM_STOP
  } frm_state_e;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_FRAME,
    PKT_GAP
  } pkt_state_e;

endpackage

// File: rtl/uart_tx_frame.sv
// Single 8N1 frame serialiser: one bit per clk_19k2 edge, line registered.
// frame_done is high during the stop bit, so a new load on that edge chains frames with no idle cycle.
module uart_tx_frame
  import uart_tx_packet_pkg::*;
(
  input  logic                      clk_19k2,
  input  logic                      rst,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      line,
  output logic                      frame_done
);

  frm_state_e                state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      line_q, line_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    line_d    = line_q;
    case (state_q)
      FRM_IDLE, FRM_STOP: begin
        if (load) begin
          state_d = FRM_START;
          data_d  = data;
          line_d  = UART_START_LVL;
        end else begin
          state_d = FRM_IDLE;
          line_d  = UART_IDLE_LVL;
        end
      end
      FRM_START: begin
        state_d   = FRM_DATA;
        bit_cnt_d = '0;
        line_d    = data_q[0];
      end
      FRM_DATA: begin
        if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
          state_d = FRM_STOP;
          line_d  = UART_STOP_LVL;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          line_d    = data_q[bit_cnt_q + 3'd1];
        end
      end
      default: begin
        state_d = FRM_IDLE;
        line_d  = UART_IDLE_LVL;
      end
    endcase
  end

  // The line level is registered together with the state it belongs to.
  always_ff @(posedge clk_19k2 or posedge rst) begin
    if (rst) begin
      state_q   <= FRM_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      line_q    <= UART_IDLE_LVL;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      line_q    <= line_d;
    end
  end

  assign line       = line_q;
  assign frame_done = (state_q == FRM_STOP);

endmodule

// File: rtl/uart_tx_packet.sv
// Five-byte UART packet transmitter: latches byte0..byte4 on send and emits back-to-back
// 8N1 frames separated by IDLE_GAP idle-high cycles, with busy/done handshake.
module uart_tx_packet
  import uart_tx_packet_pkg::*;
#(
  parameter int IDLE_GAP  = 3,
  parameter int NUM_BYTES = UART_PKT_BYTES
) (
  input  logic       clk_19k2,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic [7:0] byte3,
  input  logic [7:0] byte4,
  output logic       uart_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  pkt_state_e state_q, state_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] shadow_q [UART_PKT_BYTES];
  logic [7:0] shadow_d [UART_PKT_BYTES];
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       load;
  logic [7:0] load_byte;
  logic [2:0] next_idx;
  logic       frame_done;
  logic       line;

  assign next_idx = byte_idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    shadow_d   = shadow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_byte  = (next_idx <= LAST_IDX) ? shadow_q[next_idx] : '0;
    case (state_q)
      PKT_IDLE: begin
        if (send) begin
          shadow_d[0] = byte0;
          shadow_d[1] = byte1;
          shadow_d[2] = byte2;
          shadow_d[3] = byte3;
          shadow_d[4] = byte4;
          byte_idx_d  = '0;
          busy_d      = 1'b1;
          state_d     = PKT_FRAME;
          load        = 1'b1;
          // The shadow copy is not yet visible, so the first frame takes byte0 directly.
          load_byte   = byte0;
        end
      end
      PKT_FRAME: begin
        if (frame_done) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = PKT_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (IDLE_GAP == 0) begin
            load       = 1'b1;
            byte_idx_d = next_idx;
          end else begin
            state_d   = PKT_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      PKT_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d    = PKT_FRAME;
          load       = 1'b1;
          byte_idx_d = next_idx;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = PKT_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_19k2 or posedge rst) begin
    if (rst) begin
      state_q    <= PKT_IDLE;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      shadow_q   <= '{default: '0};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_frame u_frame (
    .clk_19k2  (clk_19k2),
    .rst       (rst),
    .load      (load),
    .data      (load_byte),
    .line      (line),
    .frame_done(frame_done)
  );

  assign uart_out = line;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_packet.sv
// Bench for uart_tx_packet: two instances (IDLE_GAP=3 and IDLE_GAP=0) against a bit-schedule model.
module tb_uart_tx_packet;

  localparam int N = 2;

  logic           clk_19k2 = 1'b0;
  logic           rst;
  logic [N-1:0]   send;
  logic [7:0]     byt [N][5];
  logic [N-1:0]   uo, bsy, dn;

  int checks = 0;
  int errors = 0;
  int gap_of [N] = '{3, 0};

  always #5 clk_19k2 = ~clk_19k2;

  uart_tx_packet #(.IDLE_GAP(3), .NUM_BYTES(5)) dut_g3 (
    .clk_19k2(clk_19k2), .rst(rst), .send(send[0]),
    .byte0(byt[0][0]), .byte1(byt[0][1]), .byte2(byt[0][2]), .byte3(byt[0][3]), .byte4(byt[0][4]),
    .uart_out(uo[0]), .busy(bsy[0]), .done(dn[0])
  );

  uart_tx_packet #(.IDLE_GAP(0), .NUM_BYTES(5)) dut_g0 (
    .clk_19k2(clk_19k2), .rst(rst), .send(send[1]),
    .byte0(byt[1][0]), .byte1(byt[1][1]), .byte2(byt[1][2]), .byte3(byt[1][3]), .byte4(byt[1][4]),
    .uart_out(uo[1]), .busy(bsy[1]), .done(dn[1])
  );

  task automatic check1(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b", name, i, act, exp);
    end
  endtask

  task automatic check8(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic checki(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, i, act, exp);
    end
  endtask

  // Model: an accepted send expands the packet into the exact list of line levels,
  // one per cycle; busy covers the list, done is the single cycle after it.
  bit           mq [N][$];
  bit [N-1:0]   infl;
  logic [N-1:0] m_line, m_busy, m_done;

  initial begin
    m_line = '1;
    m_busy = '0;
    m_done = '0;
    infl   = '0;
    forever begin
      @(posedge clk_19k2 or posedge rst);
      for (int i = 0; i < N; i++) begin
        if (rst === 1'b1) begin
          mq[i].delete();
          infl[i] = 1'b0; m_line[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        end else if (!infl[i] && send[i] === 1'b1) begin
          for (int b = 0; b < 5; b++) begin
            mq[i].push_back(1'b0);
            for (int k = 0; k < 8; k++) mq[i].push_back(byt[i][b][k]);
            mq[i].push_back(1'b1);
            if (b < 4) for (int g = 0; g < gap_of[i]; g++) mq[i].push_back(1'b1);
          end
          m_line[i] = mq[i].pop_front();
          infl[i] = 1'b1; m_busy[i] = 1'b1; m_done[i] = 1'b0;
        end else if (infl[i] && mq[i].size() > 0) begin
          m_line[i] = mq[i].pop_front();
          m_busy[i] = 1'b1; m_done[i] = 1'b0;
        end else if (infl[i]) begin
          infl[i] = 1'b0; m_line[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b1;
        end else begin
          m_line[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk_19k2) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check1("uart_out", i, uo[i], m_line[i]);
        check1("busy", i, bsy[i], m_busy[i]);
        check1("done", i, dn[i], m_done[i]);
      end
    end
  end

  // Capture buffers and a simple synchronous receiver standing in for uart_rx.
  logic       s [N][0:255];
  int         dcnt [N];
  int         didx [N];
  logic [7:0] dec [N][5];
  int         ferr [N];

  logic [7:0] exp_pkt0 [5] = '{8'hC7, 8'hF7, 8'h0E, 8'h81, 8'h45};
  logic [7:0] exp_pkt1 [5] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h01};
  logic       exp_f0 [13]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] sent [5];

  task automatic tick();
    @(negedge clk_19k2);
    #1;
  endtask

  task automatic clr_cap();
    for (int i = 0; i < N; i++) begin
      dcnt[i] = 0;
      didx[i] = -1;
      for (int c = 0; c < 256; c++) s[i][c] = 1'b1;
    end
  endtask

  task automatic sample(input int c);
    for (int i = 0; i < N; i++) begin
      s[i][c] = uo[i];
      if (dn[i] === 1'b1) begin
        dcnt[i]++;
        if (didx[i] < 0) didx[i] = c;
      end
    end
  endtask

  task automatic decode(input int i, input int len);
    int pos = 0;
    ferr[i] = 0;
    for (int b = 0; b < 5; b++) begin
      while (pos < len && s[i][pos] !== 1'b0) pos++;
      if (pos + 9 >= len) begin
        ferr[i]++;
        dec[i][b] = 8'h00;
      end else begin
        for (int k = 0; k < 8; k++) dec[i][b][k] = s[i][pos + 1 + k];
        if (s[i][pos + 9] !== 1'b1) ferr[i]++;
        pos += 10;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    send = '0;
    for (int i = 0; i < N; i++) for (int b = 0; b < 5; b++) byt[i][b] = 8'h00;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      check1("reset_line", i, uo[i], 1'b1);
      check1("reset_busy", i, bsy[i], 1'b0);
      check1("reset_done", i, dn[i], 1'b0);
    end
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Known packets; dut0 also sees byte0 changed and a second send while busy.
    byt[0] = exp_pkt0;
    byt[1] = exp_pkt1;
    send = '1;
    clr_cap();
    for (int c = 0; c < 72; c++) begin
      tick();
      sample(c);
      if (c == 0) begin
        send = '0;
        check1("busy_on_send_edge", 0, bsy[0], 1'b1);
      end
      if (c == 5) byt[0][0] = 8'h00;
      if (c == 20) send[0] = 1'b1;
      if (c == 21) send[0] = 1'b0;
    end
    for (int k = 0; k < 13; k++) check1("frame0_bit", 0, s[0][k], exp_f0[k]);
    checki("done_index", 0, didx[0], 62);
    checki("done_count", 0, dcnt[0], 1);
    checki("done_index", 1, didx[1], 50);
    checki("done_count", 1, dcnt[1], 1);
    for (int c = 63; c < 72; c++) check1("ignored_send_idle", 0, s[0][c], 1'b1);
    for (int b = 0; b < 5; b++) begin
      check1("start_pos_gap3", 0, s[0][13 * b], 1'b0);
      check1("start_pos_gap0", 1, s[1][10 * b], 1'b0);
    end
    decode(0, 62);
    decode(1, 50);
    for (int b = 0; b < 5; b++) begin
      check8("loopback_byte", 0, dec[0][b], exp_pkt0[b]);
      check8("loopback_byte", 1, dec[1][b], exp_pkt1[b]);
    end
    checki("framing", 0, ferr[0], 0);
    checki("framing", 1, ferr[1], 0);

    // send held high: packets repeat with one idle cycle between them.
    clr_cap();
    send = '1;
    for (int c = 0; c < 200; c++) begin
      tick();
      sample(c);
      for (int i = 0; i < N; i++) for (int b = 0; b < 5; b++) byt[i][b] = 8'($urandom);
    end
    send = '0;
    checki("held_done_count", 0, dcnt[0], 3);
    checki("held_done_count", 1, dcnt[1], 3);
    check1("held_idle_cycle", 0, s[0][62], 1'b1);
    check1("held_restart", 0, s[0][63], 1'b0);
    check1("held_idle_cycle", 1, s[1][50], 1'b1);
    check1("held_restart", 1, s[1][51], 1'b0);
    repeat (80) tick();

    // Reset during DATA of byte2 (byte2 = 0 so the line is low when it hits).
    for (int b = 0; b < 5; b++) byt[0][b] = 8'($urandom);
    byt[0][2] = 8'h00;
    send[0] = 1'b1;
    clr_cap();
    for (int c = 0; c <= 30; c++) begin
      tick();
      sample(c);
      if (c == 0) send[0] = 1'b0;
    end
    check1("pre_reset_line_low", 0, uo[0], 1'b0);
    rst = 1'b1;
    #1;
    check1("async_reset_line", 0, uo[0], 1'b1);
    check1("async_reset_busy", 0, bsy[0], 1'b0);
    check1("async_reset_done", 0, dn[0], 1'b0);
    tick();
    rst = 1'b0;
    clr_cap();
    for (int c = 0; c < 10; c++) begin
      tick();
      sample(c);
    end
    checki("no_done_after_abort", 0, dcnt[0], 0);
    for (int b = 0; b < 5; b++) begin
      sent[b] = 8'($urandom);
      byt[0][b] = sent[b];
    end
    send[0] = 1'b1;
    clr_cap();
    for (int c = 0; c < 66; c++) begin
      tick();
      sample(c);
      if (c == 0) send[0] = 1'b0;
    end
    decode(0, 62);
    for (int b = 0; b < 5; b++) check8("post_reset_byte", 0, dec[0][b], sent[b]);
    checki("post_reset_done_index", 0, didx[0], 62);

    // Random traffic with occasional resets, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        send[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) byt[i][$urandom_range(0, 4)] = 8'($urandom);
      end
    end
    rst = 1'b0;
    send = '0;
    repeat (70) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
